// File: rtl/lfsr_seq_ctrl.sv
// Round-robin sequencer sharing one N-bit LFSR datapath among REQS requesters.
// Each grant loads the requester's seed, steps until the seed recurs and reports the period.
module lfsr_seq_ctrl #(
   parameter  int unsigned N    = 4,
   parameter  int unsigned REQS = 4,
   localparam int unsigned ID_W = $clog2(REQS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REQS-1:0]   req,
   input  logic [REQS*N-1:0] req_seed,
   output logic [REQS-1:0]   gnt,
   output logic              busy,
   output logic              lfsr_load,
   output logic [N-1:0]      lfsr_seed,
   output logic              lfsr_en,
   input  logic [N-1:0]      lfsr_q,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic [N:0]        rsp_period,
   output logic              rsp_timeout
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StResp} state_e;

   localparam logic [N:0] MaxCount = {1'b1, {N{1'b0}}};

   state_e          r_state, w_state_d;
   logic [N-1:0]    r_seed, w_seed_d;
   logic [ID_W-1:0] r_id, w_id_d;
   logic [ID_W-1:0] r_last, w_last_d;
   logic [N:0]      r_count, w_count_d;
   logic [N:0]      r_period, w_period_d;
   logic            r_timeout, w_timeout_d;

   logic            w_any;
   logic [ID_W-1:0] w_pick;
   logic [ID_W-1:0] w_cand;
   int unsigned     w_idx;
   logic [N-1:0]    w_seed;

   // Search starts one past the last served requester so service rotates.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_idx  = 0;
      w_cand = '0;
      for (int unsigned k = 1; k <= REQS; k++) begin
         w_idx  = (32'(r_last) + k) % REQS;
         w_cand = ID_W'(w_idx);
         if (!w_any && req[w_cand]) begin
            w_any  = 1'b1;
            w_pick = w_cand;
         end
      end
   end

   always_comb begin
      w_seed = '0;
      for (int unsigned i = 0; i < REQS; i++) begin
         if (w_pick == ID_W'(i)) begin
            w_seed = req_seed[i*N +: N];
         end
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_seed_d    = r_seed;
      w_id_d      = r_id;
      w_last_d    = r_last;
      w_count_d   = r_count;
      w_period_d  = r_period;
      w_timeout_d = r_timeout;
      gnt         = '0;
      lfsr_load   = 1'b0;
      lfsr_en     = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (w_any && reset) begin
               gnt[w_pick] = 1'b1;
               w_seed_d    = w_seed;
               w_id_d      = w_pick;
               if (w_seed != '0) begin
                  w_state_d = StLoad;
               end else begin
                  // A zero seed can never cycle; report it without touching the datapath.
                  w_state_d   = StResp;
                  w_period_d  = '0;
                  w_timeout_d = 1'b1;
               end
            end
         end
         StLoad: begin
            lfsr_load = 1'b1;
            w_count_d = '0;
            w_state_d = StRun;
         end
         StRun: begin
            if (r_count != '0 && lfsr_q == r_seed) begin
               w_period_d  = r_count;
               w_timeout_d = 1'b0;
               w_state_d   = StResp;
            end else if (r_count == MaxCount) begin
               w_period_d  = MaxCount;
               w_timeout_d = 1'b1;
               w_state_d   = StResp;
            end else begin
               lfsr_en   = 1'b1;
               w_count_d = r_count + (N+1)'(1);
            end
         end
         StResp: begin
            if (rsp_ready) begin
               w_last_d  = r_id;
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_seed    <= '0;
         r_id      <= '0;
         r_last    <= ID_W'(REQS - 1);
         r_count   <= '0;
         r_period  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_seed    <= w_seed_d;
         r_id      <= w_id_d;
         r_last    <= w_last_d;
         r_count   <= w_count_d;
         r_period  <= w_period_d;
         r_timeout <= w_timeout_d;
      end
   end

   assign busy        = (r_state != StIdle);
   assign lfsr_seed   = busy ? r_seed : '0;
   assign rsp_valid   = (r_state == StResp);
   assign rsp_id      = r_id;
   assign rsp_period  = r_period;
   assign rsp_timeout = r_timeout;

   a_load_en_excl: assert property (@(posedge clk) disable iff (!reset) !(lfsr_load && lfsr_en));
   a_gnt_onehot:   assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a behavioural shift-register datapath
// whose feedback is switchable between maximal, shift-out and rotate.
module tb_lfsr_seq_ctrl;
   localparam int unsigned N    = 4;
   localparam int unsigned REQS = 4;
   localparam int unsigned ID_W = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [REQS-1:0]   req = '0;
   logic [REQS*N-1:0] req_seed = '0;
   logic [REQS-1:0]   gnt;
   logic              busy;
   logic              lfsr_load;
   logic [N-1:0]      lfsr_seed;
   logic              lfsr_en;
   logic [N-1:0]      dp_q = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [ID_W-1:0]   rsp_id;
   logic [N:0]        rsp_period;
   logic              rsp_timeout;

   logic [1:0]        mode = 2'd0;
   int                checks = 0;
   int                errors = 0;

   lfsr_seq_ctrl #(.N(N), .REQS(REQS)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_seed    (req_seed),
      .gnt         (gnt),
      .busy        (busy),
      .lfsr_load   (lfsr_load),
      .lfsr_seed   (lfsr_seed),
      .lfsr_en     (lfsr_en),
      .lfsr_q      (dp_q),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_period  (rsp_period),
      .rsp_timeout (rsp_timeout)
   );

   always #5 clk = ~clk;

   // 0: maximal {q[2:0], q3^q2}; 1: shift-out stub; 2: rotate.
   function automatic logic [3:0] dp_next(input logic [3:0] q, input logic [1:0] m);
      case (m)
         2'd0:    return {q[2:0], q[3] ^ q[2]};
         2'd1:    return {q[2:0], 1'b0};
         default: return {q[2:0], q[3]};
      endcase
   endfunction

   always @(posedge clk) begin
      if (lfsr_load)    dp_q <= lfsr_seed;
      else if (lfsr_en) dp_q <= dp_next(dp_q, mode);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      req   = '0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      logic [1:0] id;
      logic [3:0] seed;
      logic [1:0] mode;
      logic [4:0] period;
      logic       timeout;
      int         lat;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input int n, input vec_t v);
      int cyc;
      int ens;
      int loads;
      int load_cyc;
      int first_en;
      int stray;
      logic [3:0] load_seed;
      ens = 0; loads = 0; load_cyc = 0; first_en = 0; stray = 0; load_seed = '0;
      @(negedge clk);
      mode      = v.mode;
      req_seed  = '0;
      req_seed[v.id*4 +: 4] = v.seed;
      req       = 4'b0001 << v.id;
      rsp_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_grant", n), 32'(gnt), 32'(4'b0001 << v.id));
      for (cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (lfsr_load) begin
            loads++;
            load_cyc  = cyc;
            load_seed = lfsr_seed;
         end
         if (lfsr_en) begin
            if (ens == 0) first_en = cyc;
            ens++;
         end
         if (gnt != '0) stray++;
         req = '0;
         if (rsp_valid) break;
      end
      chk($sformatf("v%0d_latency", n), 32'(cyc), 32'(v.lat));
      chk($sformatf("v%0d_rsp_id", n), 32'(rsp_id), 32'(v.id));
      chk($sformatf("v%0d_rsp_period", n), 32'(rsp_period), 32'(v.period));
      chk($sformatf("v%0d_rsp_timeout", n), 32'(rsp_timeout), 32'(v.timeout));
      chk($sformatf("v%0d_en_cycles", n), 32'(ens), 32'(v.period));
      chk($sformatf("v%0d_first_en", n), 32'(first_en), (v.period != 0) ? 32'd2 : 32'd0);
      chk($sformatf("v%0d_loads", n), 32'(loads), (v.seed != 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_load_cycle", n), 32'(load_cyc), (v.seed != 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_load_seed", n), 32'(load_seed), 32'(v.seed));
      chk($sformatf("v%0d_gnt_while_busy", n), 32'(stray), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_valid_drop", n), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d_busy_drop", n), 32'(busy), 32'd0);
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 40 && busy; k++) @(negedge clk);
      chk(name, 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int order[5];
      int exp_order[5];
      int n;
      int stray;
      int bad;
      int hold_bad;
      logic [ID_W-1:0] h_id;
      logic [N:0]      h_per;
      logic            h_to;
      bit              seen;

      vecs[0] = '{id: 2'd0, seed: 4'b0001, mode: 2'd0, period: 5'd15, timeout: 1'b0, lat: 18};
      vecs[1] = '{id: 2'd2, seed: 4'b0000, mode: 2'd0, period: 5'd0,  timeout: 1'b1, lat: 1};
      vecs[2] = '{id: 2'd1, seed: 4'b0101, mode: 2'd2, period: 5'd2,  timeout: 1'b0, lat: 5};
      vecs[3] = '{id: 2'd3, seed: 4'b1111, mode: 2'd2, period: 5'd1,  timeout: 1'b0, lat: 4};
      vecs[4] = '{id: 2'd0, seed: 4'b0001, mode: 2'd1, period: 5'd16, timeout: 1'b1, lat: 19};
      vecs[5] = '{id: 2'd0, seed: 4'b0011, mode: 2'd2, period: 5'd4,  timeout: 1'b0, lat: 7};
      vecs[6] = '{id: 2'd1, seed: 4'b1000, mode: 2'd0, period: 5'd15, timeout: 1'b0, lat: 18};
      exp_order = '{0, 1, 2, 3, 0};

      // Reset state
      do_reset();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_load", 32'(lfsr_load), 32'd0);
      chk("rst_en", 32'(lfsr_en), 32'd0);
      chk("rst_seed", 32'(lfsr_seed), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      chk("rst_period", 32'(rsp_period), 32'd0);
      chk("rst_timeout", 32'(rsp_timeout), 32'd0);

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Round-robin with every requester held
      do_reset();
      @(negedge clk);
      mode = 2'd2; req_seed = 16'hFFFF; req = 4'hF; rsp_ready = 1'b1;
      #1;
      n = 0; stray = 0; bad = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (gnt != '0) begin
            if (busy) stray++;
            if (!$onehot(gnt)) bad++;
            for (int b = 0; b < 4; b++) if (gnt[b]) order[n] = b;
            n++;
            if (n == 5) break;
         end
         @(negedge clk);
      end
      chk("rr_grant_count", 32'(n), 32'd5);
      for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
      chk("rr_onehot", 32'(bad), 32'd0);
      chk("rr_gnt_while_busy", 32'(stray), 32'd0);
      @(negedge clk);
      req = '0;
      wait_idle("rr_drain");

      // Backpressure, with another requester waiting
      @(negedge clk);
      mode = 2'd2; req_seed = 16'hF050; req = 4'b0010; rsp_ready = 1'b0;
      #1;
      chk("bp_grant", 32'(gnt), 32'b0010);
      @(negedge clk);
      req = 4'b1000;
      seen = 1'b0; stray = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
         if (gnt != '0) stray++;
         @(negedge clk);
      end
      chk("bp_valid_seen", 32'(seen), 32'd1);
      h_id = rsp_id; h_per = rsp_period; h_to = rsp_timeout;
      chk("bp_id", 32'(h_id), 32'd1);
      chk("bp_period", 32'(h_per), 32'd2);
      hold_bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_id !== h_id || rsp_period !== h_per ||
             rsp_timeout !== h_to || lfsr_en !== 1'b0 || gnt !== '0) hold_bad++;
      end
      chk("bp_hold_stable", 32'(hold_bad), 32'd0);
      chk("bp_gnt_while_busy", 32'(stray), 32'd0);
      req = '0; rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_drop", 32'(rsp_valid), 32'd0);
      chk("bp_busy_drop", 32'(busy), 32'd0);

      // Reset mid-RUN: last served was requester 1
      @(negedge clk);
      mode = 2'd0; req_seed = 16'h0010; req = 4'b0010;
      #1;
      chk("mr_grant", 32'(gnt), 32'b0010);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         req = '0;
      end
      chk("mr_in_run", 32'(lfsr_en), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_en", 32'(lfsr_en), 32'd0);
      chk("mr_valid", 32'(rsp_valid), 32'd0);
      chk("mr_seed", 32'(lfsr_seed), 32'd0);
      chk("mr_period", 32'(rsp_period), 32'd0);
      bad = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (rsp_valid || busy) bad++;
      end
      chk("mr_no_response", 32'(bad), 32'd0);
      req_seed = 16'h0F50; req = 4'b0110;
      #1;
      chk("mr_ptr_reset_grant", 32'(gnt), 32'b0010);
      @(negedge clk);
      req = '0;
      wait_idle("mr_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
